// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-issue controller.
package cond_pkg;

    localparam int FLAG_LAT = 2;
    localparam int MAX_PEND = 3;
    localparam int PEND_W   = $clog2(MAX_PEND + 1);

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b1000,
        COND_NE = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    // Only these codes read NZCV and therefore have to wait for in-flight writers.
    function automatic logic is_flag_cond(input logic [3:0] code);
        return (code >= 4'b1000) && (code <= 4'b1101);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: (condition code, NZCV) -> pass.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic  n_flag;
    logic  z_flag;
    logic  v_flag;
    logic  ge;
    logic  unused_carry;
    cond_t code;

    assign n_flag       = nzcv[N_BIT];
    assign z_flag       = nzcv[Z_BIT];
    assign v_flag       = nzcv[V_BIT];
    assign unused_carry = nzcv[C_BIT];
    assign ge           = (n_flag == v_flag);
    assign code         = cond_t'(cond);

    // Undefined encodings fall into default and always squash.
    always_comb begin
        pass = 1'b0;
        case (code)
            COND_EQ: pass = z_flag;
            COND_NE: pass = ~z_flag;
            COND_GE: pass = ge;
            COND_LT: pass = ~ge;
            COND_GT: pass = ~z_flag & ge;
            COND_LE: pass = z_flag | ~ge;
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_ctrl.sv
// One-entry conditional-issue stage between decode and execute; owns NZCV.
// Optional COND_PERF_EN adds stall_cycles / squash_cnt performance counters.
module cond_issue_ctrl
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cond,
    input  logic        in_setflags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_exec,
    output logic        out_setflags,
    input  logic        fl_valid,
    input  logic [3:0]  fl_data,
    output logic [3:0]  flags,
    output logic        err
`ifdef COND_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] squash_cnt
`endif
);

    state_t              state_q, state_d;
    logic [3:0]          cond_q, cond_d;
    logic                setf_q, setf_d;
    logic [PEND_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic [3:0]          flags_q, flags_d;
    logic                err_q, err_d;

    logic                pass;
    logic                in_ready_state;
    logic                block;
    logic                hs;
    logic                accept;
    logic                pend_inc;
    logic                pend_dec;
    logic                load_wait;

    cond_eval u_cond_eval (
        .cond (cond_q),
        .nzcv (flags_q),
        .pass (pass)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cond_q     <= 4'b0000;
            setf_q     <= 1'b0;
            pend_cnt_q <= '0;
            flags_q    <= 4'b0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cond_q     <= cond_d;
            setf_q     <= setf_d;
            pend_cnt_q <= pend_cnt_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
        end
    end

    // Output logic; a full writer budget holds a setflags op back.
    always_comb begin
        out_exec       = (state_q == READY) & pass;
        out_setflags   = out_exec & setf_q;
        block          = out_setflags & (pend_cnt_q == PEND_W'(MAX_PEND));
        out_valid      = (state_q == READY) & ~block;
        in_ready_state = (state_q == IDLE) | ((state_q == READY) & out_ready & ~block);
        in_ready       = in_ready_state;
        flags          = flags_q;
        err            = err_q;
    end

    // Writer tracking and the architectural flag register.
    always_comb begin
        hs       = out_valid & out_ready & ~flush;
        accept   = in_valid & in_ready_state & ~flush;
        pend_inc = hs & out_setflags;
        pend_dec = fl_valid & (pend_cnt_q != '0);

        pend_cnt_d = pend_cnt_q;
        if (pend_inc && !pend_dec) begin
            pend_cnt_d = pend_cnt_q + PEND_W'(1);
        end else if (!pend_inc && pend_dec) begin
            pend_cnt_d = pend_cnt_q - PEND_W'(1);
        end

        flags_d = fl_valid ? fl_data : flags_q;
        err_d   = err_q | (fl_valid & (pend_cnt_q == '0));
    end

    // Next-state logic; decisions use the post-update writer count.
    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        setf_d    = setf_q;
        load_wait = is_flag_cond(in_cond) && (pend_cnt_d != '0);

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cond_d  = in_cond;
                        setf_d  = in_setflags;
                        state_d = load_wait ? WAIT : READY;
                    end
                end
                WAIT: begin
                    if (pend_cnt_d == '0) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (hs) begin
                        if (accept) begin
                            cond_d  = in_cond;
                            setf_d  = in_setflags;
                            state_d = load_wait ? WAIT : READY;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef COND_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        squash_cnt_d   = squash_cnt_q;
        if ((state_q == WAIT) || block) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (hs && !out_exec) begin
            squash_cnt_d = squash_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            squash_cnt_q   <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            squash_cnt_q   <= squash_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign squash_cnt   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed self-checking bench for cond_issue_ctrl (COND_PERF_EN optional).
module tb_cond_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic        in_setflags;
    logic        out_valid;
    logic        out_ready;
    logic        out_exec;
    logic        out_setflags;
    logic        fl_valid;
    logic [3:0]  fl_data;
    logic [3:0]  flags;
    logic        err;
`ifdef COND_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] squash_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cond_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cond      (in_cond),
        .in_setflags  (in_setflags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_exec     (out_exec),
        .out_setflags (out_setflags),
        .fl_valid     (fl_valid),
        .fl_data      (fl_data),
        .flags        (flags),
        .err          (err)
`ifdef COND_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .squash_cnt   (squash_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [3:0] t3_cond [5];
    logic       t3_exp  [5];

    initial begin
        t3_cond[0] = 4'b1011; t3_exp[0] = 1'b1;   // LT
        t3_cond[1] = 4'b1010; t3_exp[1] = 1'b0;   // GE
        t3_cond[2] = 4'b1100; t3_exp[2] = 1'b0;   // GT
        t3_cond[3] = 4'b1101; t3_exp[3] = 1'b1;   // LE
        t3_cond[4] = 4'b0011; t3_exp[4] = 1'b0;   // undefined

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cond = 4'b1110;
        in_setflags = 1'b0; out_ready = 1'b1; fl_valid = 1'b0; fl_data = 4'b0000;
        tick; tick;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_exec",  32'(out_exec),  32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_err",       32'(err),       32'd0);
        reset = 1'b1;
        tick;

        // ADDS then BEQ waiting on its flags
        in_valid = 1'b1; in_cond = 4'b1110; in_setflags = 1'b1;
        tick;
        chk("t2_adds_valid", 32'(out_valid),    32'd1);
        chk("t2_adds_sf",    32'(out_setflags), 32'd1);
        in_cond = 4'b1000; in_setflags = 1'b0;
        chk("t2_beq_accept", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("t2_wait1_valid", 32'(out_valid), 32'd0);
        chk("t2_wait1_ready", 32'(in_ready),  32'd0);
        tick;
        chk("t2_wait2_valid", 32'(out_valid), 32'd0);
        fl_valid = 1'b1; fl_data = 4'b0100;
        tick;
        fl_valid = 1'b0;
        chk("t2_beq_valid", 32'(out_valid), 32'd1);
        chk("t2_beq_exec",  32'(out_exec),  32'd1);
        chk("t2_flags",     32'(flags),     32'h4);
`ifdef COND_PERF_EN
        chk("t2_stall_cycles", stall_cycles, 32'd2);
`endif
        tick;

        // Load flags = 1000 via a setflags op, then evaluate conditions
        in_valid = 1'b1; in_cond = 4'b1110; in_setflags = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        fl_valid = 1'b1; fl_data = 4'b1000;
        tick;
        fl_valid = 1'b0;
        chk("t3_flags", 32'(flags), 32'h8);
        chk("t3_pend0", 32'(dut.pend_cnt_q), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cond = t3_cond[i]; in_setflags = 1'b0;
            tick;
            chk($sformatf("t3_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t3_exec_%0d", i),  32'(out_exec),  32'(t3_exp[i]));
        end
        in_valid = 1'b0;
        tick;
`ifdef COND_PERF_EN
        chk("t3_squash_cnt", squash_cnt, 32'd3);
`endif

        // Writer budget exhaustion
        in_valid = 1'b1; in_cond = 4'b1110; in_setflags = 1'b1;
        tick; tick; tick; tick;
        in_valid = 1'b0;
        chk("t4_pend3",       32'(dut.pend_cnt_q), 32'd3);
        chk("t4_held_valid",  32'(out_valid),      32'd0);
        chk("t4_held_ready",  32'(in_ready),       32'd0);
        tick;
        chk("t4_held_valid2", 32'(out_valid), 32'd0);
        fl_valid = 1'b1; fl_data = 4'b0000;
        tick;
        fl_valid = 1'b0;
        chk("t4_issue_valid", 32'(out_valid), 32'd1);
`ifdef COND_PERF_EN
        chk("t4_stall_cycles", stall_cycles, 32'd4);
`endif
        out_ready = 1'b0;
        tick;
        chk("t4_hold_valid", 32'(out_valid),    32'd1);
        chk("t4_hold_sf",    32'(out_setflags), 32'd1);
        out_ready = 1'b1;
        tick;
        chk("t4_pend_after", 32'(dut.pend_cnt_q), 32'd3);

        // Simultaneous increment/decrement, then flush in WAIT
        fl_valid = 1'b1;
        tick; tick;
        fl_valid = 1'b0;
        chk("t5_pend1", 32'(dut.pend_cnt_q), 32'd1);
        in_valid = 1'b1; in_cond = 4'b1110; in_setflags = 1'b1;
        tick;
        in_valid = 1'b0;
        fl_valid = 1'b1; fl_data = 4'b0010;
        tick;
        fl_valid = 1'b0;
        chk("t5_pend_same", 32'(dut.pend_cnt_q), 32'd1);
        chk("t5_flags",     32'(flags),          32'h2);
        in_valid = 1'b1; in_cond = 4'b1000; in_setflags = 1'b0;
        tick;
        in_valid = 1'b0;
        chk("t5_wait_valid", 32'(out_valid), 32'd0);
        chk("t5_wait_ready", 32'(in_ready),  32'd0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("t5_flush_ready", 32'(in_ready),       32'd1);
        chk("t5_flush_valid", 32'(out_valid),      32'd0);
        chk("t5_flush_pend",  32'(dut.pend_cnt_q), 32'd1);
        tick;
        chk("t5_flush_valid2", 32'(out_valid), 32'd0);
        fl_valid = 1'b1; fl_data = 4'b0101;
        tick;
        fl_valid = 1'b0;
        chk("t5_err_clear", 32'(err),            32'd0);
        chk("t5_pend_zero", 32'(dut.pend_cnt_q), 32'd0);

        // Spurious flag return
        fl_valid = 1'b1; fl_data = 4'b0101;
        tick;
        fl_valid = 1'b0;
        chk("t6_err_set", 32'(err),            32'd1);
        chk("t6_flags",   32'(flags),          32'h5);
        chk("t6_pend",    32'(dut.pend_cnt_q), 32'd0);
        tick;
        chk("t6_err_sticky", 32'(err), 32'd1);

        // Reset asserted mid-WAIT with two writers outstanding
        in_valid = 1'b1; in_cond = 4'b1110; in_setflags = 1'b1;
        tick; tick;
        in_cond = 4'b1000; in_setflags = 1'b0;
        tick;
        in_valid = 1'b0;
        chk("t1_pend2",       32'(dut.pend_cnt_q), 32'd2);
        chk("t1_wait_valid",  32'(out_valid),      32'd0);
        chk("t1_wait_ready",  32'(in_ready),       32'd0);
        reset = 1'b0;
        tick;
        chk("t1_rst_flags",    32'(flags),          32'd0);
        chk("t1_rst_pend",     32'(dut.pend_cnt_q), 32'd0);
        chk("t1_rst_valid",    32'(out_valid),      32'd0);
        chk("t1_rst_in_ready", 32'(in_ready),       32'd1);
        chk("t1_rst_err",      32'(err),            32'd0);
        reset = 1'b1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
